// File: rtl/gpr_dump_unit_if.sv
// Output beat stream of the GPR dump unit.
// master drives a beat (valid/data/index/last); slave returns ready.
interface gpr_dump_unit_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;

   modport master (output out_valid, out_data, out_index, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/gpr_dump_unit.sv
// GPR dump unit: walks register indices 0..NREG-1 through a combinational
// GPR read port and streams each value out as a valid/ready beat.
// Optional feature macro GPR_DUMP_CHECKSUM_EN appends one extra beat
// carrying the XOR of all dumped words (out_index=0, out_last=1).
module gpr_dump_unit #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int IDX_W  = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   output logic [IDX_W-1:0]   gpr_rd_num,
   input  logic [DATA_W-1:0]  gpr_rd_data,
   gpr_dump_unit_if.master    out_if,
   output logic               busy,
   output logic               done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEND = 3'd2,
`ifdef GPR_DUMP_CHECKSUM_EN
      CSUM = 3'd4,
`endif
      DONE = 3'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
   logic              out_last_q, out_last_d;
`ifdef GPR_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   logic hs;
   assign hs = out_valid_q & out_if.out_ready;

   // State and beat registers; reset wins over any pending handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         index_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
`ifdef GPR_DUMP_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Next-state and beat capture; the beat registers hold while stalled
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
`ifdef GPR_DUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               index_d = '0;
`ifdef GPR_DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = LOAD;
            end
         end
         LOAD: begin
            out_valid_d = 1'b1;
            out_data_d  = gpr_rd_data;
            out_index_d = index_q;
`ifdef GPR_DUMP_CHECKSUM_EN
            out_last_d  = 1'b0;   // last is reserved for the checksum beat
`else
            out_last_d  = (index_q == LAST_IDX);
`endif
            state_d     = SEND;
         end
         SEND: begin
            if (hs) begin
               out_valid_d = 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
               csum_d      = csum_q ^ out_data_q;
`endif
               if (index_q != LAST_IDX) begin
                  index_d = index_q + 1'b1;
                  state_d = LOAD;
               end else begin
`ifdef GPR_DUMP_CHECKSUM_EN
                  // fold the final word in directly so CSUM can present at once
                  out_valid_d = 1'b1;
                  out_data_d  = csum_q ^ out_data_q;
                  out_index_d = '0;
                  out_last_d  = 1'b1;
                  state_d     = CSUM;
`else
                  state_d     = DONE;
`endif
               end
            end
         end
`ifdef GPR_DUMP_CHECKSUM_EN
         CSUM: begin
            if (hs) begin
               out_valid_d = 1'b0;
               state_d     = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign gpr_rd_num       = index_q;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_index = out_index_q;
   assign out_if.out_last  = out_last_q;

endmodule
